// File: rtl/pe_traffic_gen_256.sv
// ---------------------------------------------------------------------------
// pe_traffic_gen_256
//
// Closed-loop traffic generator for a 256-bit PE wrapper. Each run issues
// NUM_TXN requests, one at a time. Every request payload is eight 32-bit
// words derived from a Galois LFSR. After each request the block waits for
// the matching response and measures how many cycles it took. A response
// counts as a mismatch when its two 128-bit halves differ. A response that
// has not arrived once the wait counter reaches TIMEOUT ends the run with a
// sticky error.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : asynchronous, active-high; forces IDLE and LFSR=SEED
//   start          : begins a run when sampled high in IDLE or DONE
//   m_tvalid/m_tdata/m_tready : request stream toward the PE wrapper
//   s_tvalid/s_tdata/s_tready : response stream from the PE wrapper
//   busy           : high while in SEND or WAIT
//   done           : high while in DONE (held until the next accepted start)
//   error          : sticky timeout flag for the current run
//   txn_count      : responses accepted this run (saturating)
//   last_latency   : wait cycles of the most recent accepted response
//   mismatch_count : responses with differing halves this run (saturating)
// ---------------------------------------------------------------------------
module pe_traffic_gen_256 #(
    parameter int unsigned NUM_TXN = 16,
    parameter int unsigned TIMEOUT = 63,
    parameter logic [31:0] SEED    = 32'hACE1_0001
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         m_tvalid,
    output logic [255:0] m_tdata,
    input  logic         m_tready,
    input  logic         s_tvalid,
    input  logic [255:0] s_tdata,
    output logic         s_tready,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  txn_count,
    output logic [7:0]   last_latency,
    output logic [15:0]  mismatch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] NUM_TXN_L = 16'(NUM_TXN);
    localparam logic [7:0]  TIMEOUT_L = 8'(TIMEOUT);
    // Right-shifting Galois form of x^32+x^22+x^2+x+1: term x^e feeds bit e-1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [7:0]  wait_q, wait_d;
    logic        error_q, error_d;
    logic [15:0] txn_q, txn_d;
    logic [15:0] mism_q, mism_d;
    logic [7:0]  lat_q, lat_d;

    logic [15:0] txn_inc;
    logic [15:0] mism_inc;
    logic [31:0] lfsr_step;
    logic        halves_differ;

    always_comb begin
        txn_inc       = (txn_q == 16'hFFFF) ? txn_q : txn_q + 16'd1;
        mism_inc      = (mism_q == 16'hFFFF) ? mism_q : mism_q + 16'd1;
        lfsr_step     = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
        halves_differ = (s_tdata[255:128] != s_tdata[127:0]);
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        wait_d  = wait_q;
        error_d = error_q;
        txn_d   = txn_q;
        mism_d  = mism_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    txn_d   = 16'd0;
                    mism_d  = 16'd0;
                    lat_d   = 8'd0;
                    error_d = 1'b0;
                    wait_d  = 8'd0;
                    state_d = (NUM_TXN_L == 16'd0) ? DONE : SEND;
                end
            end
            SEND: begin
                // Payload is a pure function of lfsr_q, so it stays put
                // until this handshake advances the LFSR.
                if (m_tready) begin
                    lfsr_d  = lfsr_step;
                    wait_d  = 8'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response wins over the timeout when both land together.
                if (s_tvalid) begin
                    lat_d   = wait_q;
                    txn_d   = txn_inc;
                    if (halves_differ) begin
                        mism_d = mism_inc;
                    end
                    state_d = (txn_inc == NUM_TXN_L) ? DONE : SEND;
                end else if (wait_q == TIMEOUT_L) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            wait_q  <= 8'd0;
            error_q <= 1'b0;
            txn_q   <= 16'd0;
            mism_q  <= 16'd0;
            lat_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            wait_q  <= wait_d;
            error_q <= error_d;
            txn_q   <= txn_d;
            mism_q  <= mism_d;
            lat_q   <= lat_d;
        end
    end

    // Word k of the payload is the LFSR value tagged with its word index.
    for (genvar gi = 0; gi < 8; gi++) begin : g_word
        assign m_tdata[32*gi +: 32] = lfsr_q ^ {29'b0, 3'(gi)};
    end

    assign m_tvalid       = (state_q == SEND);
    assign s_tready       = (state_q == WAIT);
    assign busy           = (state_q == SEND) || (state_q == WAIT);
    assign done           = (state_q == DONE);
    assign error          = error_q;
    assign txn_count      = txn_q;
    assign last_latency   = lat_q;
    assign mismatch_count = mism_q;

endmodule

// File: tb/tb_pe_traffic_gen_256.sv
// ---------------------------------------------------------------------------
// tb_pe_traffic_gen_256
//
// Two generator instances share the stream inputs: dut_a (NUM_TXN=4,
// TIMEOUT=63) and dut_b (NUM_TXN=3, TIMEOUT=10). Only the instance selected
// by sel is started at any time; the other sits in IDLE or DONE, where the
// stream inputs have no effect. Expected payloads and counters come from a
// transaction-level model kept in this file.
// ---------------------------------------------------------------------------
module tb_pe_traffic_gen_256;

    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         start_a = 1'b0, start_b = 1'b0;
    logic         m_tready = 1'b0;
    logic         s_tvalid = 1'b0;
    logic [255:0] s_tdata = '0;

    logic         a_m_tvalid, b_m_tvalid, a_s_tready, b_s_tready;
    logic [255:0] a_m_tdata, b_m_tdata;
    logic         a_busy, b_busy, a_done, b_done, a_error, b_error;
    logic [15:0]  a_txn, b_txn, a_mism, b_mism;
    logic [7:0]   a_lat, b_lat;

    pe_traffic_gen_256 #(.NUM_TXN(4), .TIMEOUT(63), .SEED(SEED)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .m_tvalid(a_m_tvalid), .m_tdata(a_m_tdata), .m_tready(m_tready),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(a_s_tready),
        .busy(a_busy), .done(a_done), .error(a_error),
        .txn_count(a_txn), .last_latency(a_lat), .mismatch_count(a_mism)
    );

    pe_traffic_gen_256 #(.NUM_TXN(3), .TIMEOUT(10), .SEED(SEED)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .m_tvalid(b_m_tvalid), .m_tdata(b_m_tdata), .m_tready(m_tready),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(b_s_tready),
        .busy(b_busy), .done(b_done), .error(b_error),
        .txn_count(b_txn), .last_latency(b_lat), .mismatch_count(b_mism)
    );

    // Selected-instance view of the outputs.
    int           sel = 0;
    logic         m_tvalid, s_tready, busy, done, error;
    logic [255:0] m_tdata;
    logic [15:0]  txn_count, mismatch_count;
    logic [7:0]   last_latency;
    always_comb begin
        m_tvalid       = (sel == 1) ? b_m_tvalid : a_m_tvalid;
        m_tdata        = (sel == 1) ? b_m_tdata  : a_m_tdata;
        s_tready       = (sel == 1) ? b_s_tready : a_s_tready;
        busy           = (sel == 1) ? b_busy     : a_busy;
        done           = (sel == 1) ? b_done     : a_done;
        error          = (sel == 1) ? b_error    : a_error;
        txn_count      = (sel == 1) ? b_txn      : a_txn;
        mismatch_count = (sel == 1) ? b_mism     : a_mism;
        last_latency   = (sel == 1) ? b_lat      : a_lat;
    end

    // Reference model state.
    int          assertions = 0;
    int          failures = 0;
    logic [31:0] mdl_lfsr [2];
    int          n_txn [2];
    int          exp_txn, exp_mism, exp_lat;
    int          txn_id = 0;

    // One Galois step of x^32+x^22+x^2+x+1: the bit shifted out of the
    // bottom re-enters at the positions of the polynomial terms (x^e -> bit e-1).
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) begin
            r[31] = ~r[31];
            r[21] = ~r[21];
            r[1]  = ~r[1];
            r[0]  = ~r[0];
        end
        return r;
    endfunction

    function automatic logic [255:0] payload(input logic [31:0] v);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = v ^ 32'(k);
        return d;
    endfunction

    task automatic set_start(input logic v);
        if (sel == 1) start_b = v;
        else          start_a = v;
    endtask

    // Called at a falling edge with the selected DUT in IDLE or DONE.
    task automatic start_run(input int which);
        sel = which;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        exp_txn = 0; exp_mism = 0; exp_lat = 0;
        assertions++;
        if (txn_count !== 16'd0 || mismatch_count !== 16'd0 || last_latency !== 8'd0 || error !== 1'b0) begin
            failures++;
            $display("FAIL start_clear: txn=%0d mism=%0d lat=%0d err=%0b, expected all 0", txn_count, mismatch_count, last_latency, error);
        end
        assertions++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL start_busy: busy=%0b done=%0b, expected busy=1 done=0", busy, done);
        end
    endtask

    // Request phase: DUT in SEND at entry; ready withheld for 'stall' cycles.
    task automatic do_req(input int stall);
        logic [255:0] exp_d;
        exp_d = payload(mdl_lfsr[sel]);
        for (int i = 0; i <= stall; i++) begin
            assertions++;
            if (m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
                failures++;
                $display("FAIL req_valid: m_tvalid=%0b s_tready=%0b, expected 1/0", m_tvalid, s_tready);
            end
            assertions++;
            if (m_tdata !== exp_d) begin
                failures++;
                $display("FAIL req_data: got %h expected %h", m_tdata, exp_d);
            end
            m_tready = (i == stall);
            s_tvalid = 1'($urandom_range(0, 1)); // must be ignored outside WAIT
            s_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        mdl_lfsr[sel] = lfsr_next(mdl_lfsr[sel]);
    endtask

    // Response phase: DUT in WAIT at entry; response after 'delay' idle cycles.
    task automatic do_rsp(input int delay, input logic bad, input logic start_noise);
        logic [127:0] x;
        for (int i = 0; i <= delay; i++) begin
            assertions++;
            if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL rsp_wait: s_tready=%0b m_tvalid=%0b busy=%0b, expected 1/0/1", s_tready, m_tvalid, busy);
            end
            assertions++;
            if (txn_count !== 16'(exp_txn) || error !== 1'b0) begin
                failures++;
                $display("FAIL rsp_hold: txn=%0d err=%0b, expected txn=%0d err=0", txn_count, error, exp_txn);
            end
            if (i < delay) begin
                set_start(start_noise & 1'($urandom_range(0, 1)));
                s_tvalid = 1'b0;
            end else begin
                set_start(1'b0);
                x = {$urandom, $urandom, $urandom, $urandom};
                s_tvalid = 1'b1;
                s_tdata  = bad ? {x ^ (128'd1 << $urandom_range(0, 127)), x} : {x, x};
            end
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        set_start(1'b0);
        exp_txn++;
        exp_lat = delay;
        if (bad) exp_mism++;
        txn_id++;
        $display("txn %0d dut=%0d n=%0d lat=%0d bad=%0b -> txn_count=%0d latency=%0d mismatches=%0d", txn_id, sel, exp_txn, delay, bad, txn_count, last_latency, mismatch_count);
        assertions++;
        if (txn_count !== 16'(exp_txn) || last_latency !== 8'(exp_lat) || mismatch_count !== 16'(exp_mism)) begin
            failures++;
            $display("FAIL rsp_counters: txn=%0d lat=%0d mism=%0d, expected %0d/%0d/%0d", txn_count, last_latency, mismatch_count, exp_txn, exp_lat, exp_mism);
        end
        assertions++;
        if (done !== (exp_txn == n_txn[sel]) || error !== 1'b0) begin
            failures++;
            $display("FAIL rsp_next: done=%0b err=%0b, expected done=%0b err=0", done, error, exp_txn == n_txn[sel]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        assertions++;
        if ({a_m_tvalid, a_s_tready, a_busy, a_done, a_error, b_m_tvalid, b_s_tready, b_busy, b_done, b_error} !== 10'b0 ||
            {a_txn, a_mism, a_lat, b_txn, b_mism, b_lat} !== 80'b0) begin
            failures++;
            $display("FAIL reset_state: a_busy=%0b a_done=%0b a_txn=%0d b_busy=%0b b_done=%0b b_txn=%0d, expected all 0", a_busy, a_done, a_txn, b_busy, b_done, b_txn);
        end
        assertions++;
        if (a_m_tdata[31:0] !== SEED) begin
            failures++;
            $display("FAIL reset_seed: word0=%h expected %h", a_m_tdata[31:0], SEED);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore();
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {8{$urandom}};
            @(negedge clk);
            assertions++;
            if (s_tready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || txn_count !== 16'd0) begin
                failures++;
                $display("FAIL idle_ignore: s_tready=%0b busy=%0b done=%0b txn=%0d, expected 0/0/0/0", s_tready, busy, done, txn_count);
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_echo();
        start_run(0);
        for (int t = 0; t < 4; t++) begin
            do_req(0);
            do_rsp(20, 1'b0, 1'b0);
        end
        // done persists and start-less idling changes nothing
        repeat (3) @(negedge clk);
        assertions++;
        if (done !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0 || txn_count !== 16'd4 || last_latency !== 8'd20) begin
            failures++;
            $display("FAIL echo_done: done=%0b busy=%0b txn=%0d lat=%0d, expected 1/0/4/20", done, busy, txn_count, last_latency);
        end
    endtask

    task automatic test_mismatch();
        start_run(0);
        for (int t = 1; t <= 4; t++) begin
            do_req(0);
            do_rsp($urandom_range(0, 15), t == 2, 1'b0);
        end
        assertions++;
        if (mismatch_count !== 16'd1 || txn_count !== 16'd4 || error !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_run: mism=%0d txn=%0d err=%0b, expected 1/4/0", mismatch_count, txn_count, error);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            start_run(0);
            for (int t = 0; t < 4; t++) begin
                do_req($urandom_range(0, 3));
                do_rsp($urandom_range(0, 40), ($urandom_range(0, 3) == 0), 1'b1);
            end
        end
    endtask

    task automatic test_stall();
        start_run(0);
        do_req(5);
        do_rsp(2, 1'b0, 1'b1);
        // next request must carry exactly one LFSR step past the stalled one
        do_req(0);
        do_rsp(0, 1'b0, 1'b0);
        do_req(1);
        do_rsp(63, 1'b0, 1'b0);
        do_req(0);
        do_rsp(1, 1'b1, 1'b0);
    endtask

    task automatic test_boundary();
        start_run(1);
        do_req(0);
        do_rsp(10, 1'b0, 1'b0);
        do_req(2);
        do_rsp(0, 1'b0, 1'b1);
        do_req(0);
        do_rsp(9, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        start_run(1);
        do_req(0);
        for (int i = 0; i <= 10; i++) begin
            assertions++;
            if (s_tready !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait: cycle %0d s_tready=%0b err=%0b done=%0b, expected 1/0/0", i, s_tready, error, done);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            assertions++;
            if (error !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || txn_count !== 16'd0 || s_tready !== 1'b0) begin
                failures++;
                $display("FAIL timeout_done: err=%0b done=%0b busy=%0b txn=%0d s_tready=%0b, expected 1/1/0/0/0", error, done, busy, txn_count, s_tready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        start_run(0);
        do_req(0);
        do_rsp(4, 1'b1, 1'b0);
        do_req(0);
        repeat (3) @(negedge clk);
        #2;
        reset   = 1'b1;
        start_a = 1'b1;
        #1;
        assertions++;
        if ({a_m_tvalid, a_s_tready, a_busy, a_done, a_error, b_done, b_error} !== 7'b0 ||
            {a_txn, a_mism, a_lat} !== 40'b0) begin
            failures++;
            $display("FAIL reset_mid: a_busy=%0b a_s_tready=%0b a_txn=%0d a_mism=%0d b_err=%0b, expected all 0", a_busy, a_s_tready, a_txn, a_mism, b_error);
        end
        repeat (2) @(negedge clk);
        start_a = 1'b0;
        reset   = 1'b0;
        mdl_lfsr[0] = SEED;
        mdl_lfsr[1] = SEED;
        repeat (2) @(negedge clk);
        assertions++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_restart: busy=%0b done=%0b, expected 0/0", a_busy, a_done);
        end
        start_run(0);
        assertions++;
        if (m_tdata[31:0] !== SEED) begin
            failures++;
            $display("FAIL reset_reseed: word0=%h expected %h", m_tdata[31:0], SEED);
        end
        for (int t = 0; t < 4; t++) begin
            do_req($urandom_range(0, 2));
            do_rsp($urandom_range(0, 8), 1'b0, 1'b0);
        end
    endtask

    initial begin
        mdl_lfsr[0] = SEED;
        mdl_lfsr[1] = SEED;
        n_txn[0] = 4;
        n_txn[1] = 3;
        test_reset();
        test_idle_ignore();
        test_echo();
        test_mismatch();
        test_random();
        test_stall();
        test_boundary();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
